// File: rtl/fop_pkg.sv
`default_nettype none
// fop_pkg: shared FoP mask, window-counter state type and counter-width helper.
// Rev 1.0
package fop_pkg;

  // Bit n set when n is Fibonacci or prime: {0,1,2,3,5,7,8,11,13}
  localparam logic [15:0] FOP_MASK = 16'h29AF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_e;

  function automatic int cnt_width(input int window);
    return $clog2(window + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fop_classify.sv
`default_nettype none
// fop_classify: combinational Fibonacci-or-Prime decision for one nibble.
// Rev 1.0
module fop_classify
  import fop_pkg::*;
(
  input  logic [3:0] data_i,
  output logic       fop_o
);

  assign fop_o = FOP_MASK[data_i];

endmodule
`default_nettype wire

// File: rtl/fop_window_counter.sv
`default_nettype none
// fop_window_counter: per-window FoP hit count and longest hit run over a
// valid/ready stream. Macro FOP_RUN_TRACK_EN enables max_run (else tied to 0). Rev 1.0
module fop_window_counter
  import fop_pkg::*;
#(
  parameter  int WINDOW = 16,
  localparam int CNT_W  = cnt_width(WINDOW)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  output logic             hit_flag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] max_run
);

  state_e           state_q;
  logic [CNT_W-1:0] smp_q, smp_d;
  logic [CNT_W-1:0] hits_q, hits_d;
  logic [CNT_W-1:0] hit_cnt_q;
  logic             hit_flag_q;
  logic             out_valid_q;
  logic             hit;
  logic             accept;
  logic             last;
  logic             handshake;

  fop_classify u_classify (
    .data_i (in_data),
    .fop_o  (hit)
  );

  assign in_ready  = (state_q != REPORT);
  assign accept    = in_valid && in_ready;
  assign handshake = (state_q == REPORT) && out_ready;
  assign last      = (smp_q == CNT_W'(WINDOW - 1));
  assign hits_d    = hits_q + CNT_W'(hit);
  assign smp_d     = smp_q + CNT_W'(1);

  assign hit_flag  = hit_flag_q;
  assign out_valid = out_valid_q;
  assign hit_cnt   = hit_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      smp_q       <= '0;
      hits_q      <= '0;
      hit_cnt_q   <= '0;
      hit_flag_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (clear) begin
      // Abort wins over any sample or handshake presented this cycle
      state_q     <= IDLE;
      smp_q       <= '0;
      hits_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            hit_flag_q <= hit;
            hits_q     <= hits_d;
            if (last) begin
              smp_q       <= '0;
              hit_cnt_q   <= hits_d;
              out_valid_q <= 1'b1;
              state_q     <= REPORT;
            end else begin
              smp_q   <= smp_d;
              state_q <= ACCUM;
            end
          end
        end
        REPORT: begin
          if (out_ready) begin
            hits_q      <= '0;
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef FOP_RUN_TRACK_EN
  logic [CNT_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] best_q, best_d;
  logic [CNT_W-1:0] max_run_q;

  assign run_d   = hit ? (run_q + CNT_W'(1)) : '0;
  assign best_d  = (run_d > best_q) ? run_d : best_q;
  assign max_run = max_run_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q     <= '0;
      best_q    <= '0;
      max_run_q <= '0;
    end else if (clear) begin
      run_q  <= '0;
      best_q <= '0;
    end else if (accept) begin
      run_q  <= run_d;
      best_q <= best_d;
      if (last) begin
        max_run_q <= best_d;
      end
    end else if (handshake) begin
      run_q  <= '0;
      best_q <= '0;
    end
  end
`else
  assign max_run = '0;
`endif

endmodule
`default_nettype wire
